// File: rtl/aes_cipher_iter_if.sv
// Handshake and data bundle for the iterative AES encryption core.
// The bench or wrapper takes the master side; the core takes the slave side.
interface aes_cipher_iter_if #(
    parameter int x = 0
);
    logic                         start;
    logic [0:127]                 in;
    logic [0:128*(2*x+11)-1]      words;
    logic [0:127]                 out;
    logic                         busy;
    logic                         done;
    logic [4:0]                   round;

    modport master (
        output start, in, words,
        input  out, busy, done, round
    );

    modport slave (
        input  start, in, words,
        output out, busy, done, round
    );
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one cipher round per clock, AES-128/192/256
// selected by x; the ciphertext is returned with a single-cycle done pulse.
module aes_cipher_iter #(
    parameter int x = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_cipher_iter_if.slave  bus
);
    localparam int         NR   = 10 + 2 * x;
    localparam int         NK   = NR + 1;
    localparam logic [4:0] NR_L = 5'(NR);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    // Multiply by 2 in GF(2^8), reducing by 0x11B when bit 7 carries out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes fused with ShiftRows: output (r,c) takes input (r,(c+r) mod 4).
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [0:127] state_q, state_d;
    logic [0:127] out_q, out_d;
    logic [4:0]   round_q, round_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [0:127] rk_s;
    logic [0:127] sr_s;
    logic [0:127] mc_s;

    // Round-key mux: only indices 0..Nr exist, so no slice can leave the schedule.
    always_comb begin
        rk_s = bus.words[0 +: 128];
        for (int k = 1; k < NK; k++) begin
            rk_s = (round_q == 5'(k)) ? bus.words[128*k +: 128] : rk_s;
        end
    end

    // Round datapath shared by middle and final rounds.
    always_comb begin
        sr_s = sub_shift(state_q);
        mc_s = mix_columns(sr_s);
    end

    // Next-state logic for the round sequencer and the registered outputs.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        out_d   = out_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.in ^ rk_s;
                    round_d = 5'd1;
                    fsm_d   = RUN;
                end else begin
                    fsm_d   = IDLE;
                end
            end
            RUN: begin
                if (round_q == NR_L) begin
                    out_d   = sr_s ^ rk_s;
                    done_d  = 1'b1;
                    round_d = 5'd0;
                    fsm_d   = IDLE;
                end else begin
                    state_d = mc_s ^ rk_s;
                    round_d = round_q + 5'd1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 5'd0;
            end
        endcase
        busy_d = (fsm_d == RUN);
    end

    // State, output and control registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= 128'h0;
            out_q   <= 128'h0;
            round_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            out_q   <= out_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.round = round_q;
endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
Iterative AES encryption core, the forward counterpart of the team's round-based decipher datapath. Takes one 128-bit plaintext block and the fully expanded key schedule. Runs one cipher round per clock under an internal round counter and returns the ciphertext with a one-cycle done pulse. Supports AES-128/192/256 through the same x parameter used across the codebase. It sits beside the decipher in the top-level AES wrapper, fed by the existing key-expansion block.

Parameters:
x, 0, key-size select: 0 = AES-128, 1 = AES-192, 2 = AES-256; Nr = 10+2*x rounds; key schedule holds 2*x+11 round keys.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to encrypt `in`; sampled only when busy=0
in  input  [0:127]  plaintext; bits [0:7] = byte 0; column-major state (byte r+4c = row r, col c)
words  input  [0:128*(2*x+11)-1]  expanded key; round key k = words[128*k +: 128]; k=0 is initial AddRoundKey; must be stable while busy=1
out  output  [0:127]  ciphertext; holds its value until the next completion
busy  output  1  high while rounds are in progress
done  output  1  one-cycle pulse when `out` is updated
round  output  [4:0]  current round index (0 when idle), for debug and bench visibility

Behaviour:
- Reset (rst_n=0, async): state register=0, out=0, round=0, busy=0, done=0, FSM=IDLE. Takes effect immediately, including mid-operation. The in-flight block is discarded and done is never raised for it.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, round 1..Nr.
- IDLE + start=1 at edge T:
  - state <= in ^ rk0; round <= 1; busy <= 1; FSM -> RUN.
  - `in` is captured only at this edge.
- RUN, round r with 1 <= r < Nr:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_r; round <= r+1.
- RUN, round r = Nr (final round, no MixColumns):
  - out <= ShiftRows(SubBytes(state)) ^ rk_Nr; done <= 1; busy <= 0; round <= 0; FSM -> IDLE.
- Latency: start edge at T gives done=1 and valid out after edge T+Nr. That is 10/12/14 cycles for x=0/1/2.
- done is high for exactly one cycle. It is cleared at the next edge unconditionally.
- start while busy=1: ignored. No queueing, no effect on the running block.
- start in the cycle done is high: accepted, since FSM is already IDLE. Back-to-back throughput is one block per Nr+1 cycles.
- SubBytes: 16 parallel forward S-boxes (FIPS-197 table), combinational.
- ShiftRows: row r rotated left by r bytes.
- MixColumns: GF(2^8) with polynomial 0x11B; xtime reduction on bit-7 carry.
- All datapath logic between state and state is combinational. Only state, out, round, busy, done and FSM are registered.
- words is indexed by round with a constant-width 128-bit slice. No out-of-range index may be generated for any x.

Test Plan:
- FIPS-197 App. B, x=0: key 2b7e151628aed2a6abf7158809cf4f3c expanded, in=3243f6a8885a308d313198a2e0370734, start pulse -> done after 10 cycles, out=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1/C.2/C.3, x=0/1/2: key 000102…(16/24/32 bytes) expanded, in=00112233445566778899aabbccddeeff -> out=69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089, with latency 10/12/14.
- Start while busy: second start with a different `in` at cycle 4 of the App. B run -> out still 3925841d…0b32, exactly one done pulse.
- Back-to-back: start asserted in the done cycle with C.1 plaintext -> second done exactly 11 cycles after the first, out=69c4e0d8…c55a. The first out stays stable until the second done.
- Reset mid-run: rst_n low at round 5 -> out=0, busy=0, done=0 immediately, no done pulse. A subsequent App. B run gives the correct result.
- Round counter: during a C.1 run, round steps 1..10 on successive cycles and returns to 0 with busy=0 in the done cycle.
